// File: rtl/pe_func_cfg_loader_pkg.sv
// Shared definitions for the PE ALU_func configuration loader: frame magic,
// loader FSM states and the set of ALU_func codes a PE tile understands.
package pe_cfg_pkg;

    localparam logic [7:0] CFG_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        TRAILER,
        COMMIT,
        DRAIN
    } cfg_state_e;

    // Codes 2 and 7 are unassigned in the PE ALU and must never reach a tile
    localparam logic [2:0] FUNC_ADD  = 3'd0;
    localparam logic [2:0] FUNC_SUB  = 3'd1;
    localparam logic [2:0] FUNC_AND  = 3'd3;
    localparam logic [2:0] FUNC_OR   = 3'd4;
    localparam logic [2:0] FUNC_XOR  = 3'd5;
    localparam logic [2:0] FUNC_PASS = 3'd6;

    function automatic logic func_legal(input logic [2:0] code);
        case (code)
            FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_PASS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pe_func_cfg_loader_if.sv
// Valid/ready config word stream feeding the loader; master is the word
// source, slave is the loader.
interface pe_func_cfg_loader_if #(
    parameter int WORD_W = 32
) ();
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_last;

    modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);
endinterface

// File: rtl/pe_func_cfg_loader.sv
// Decodes framed config words into per-PE ALU_func fields. A frame is staged
// in a shadow copy and only a fully checked frame is committed to the PEs.
module pe_func_cfg_loader
    import pe_cfg_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int FUNC_W = 3,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     resetn,
    pe_func_cfg_loader_if.slave      cfg,
    output logic [NUM_PE*FUNC_W-1:0] alu_func_o,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic                     busy
);

    localparam logic [8:0] NUM_PE_W = 9'(NUM_PE);

    cfg_state_e        state_reg, state_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [WORD_W-1:0] csum_reg, csum_next;
    logic [FUNC_W-1:0] shadow_reg [NUM_PE];
    logic [FUNC_W-1:0] shadow_next [NUM_PE];
    logic [FUNC_W-1:0] live_reg [NUM_PE];
    logic [FUNC_W-1:0] live_next [NUM_PE];
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic              ready;
    logic              accept;
    logic [WORD_W-1:0] word;
    logic              last;
    logic              hdr_ok;
    logic              pay_ok;
    logic [7:0]        pay_idx;
    logic [2:0]        pay_func;

    // Ready is forced low while reset is held so no word is taken then
    assign ready         = resetn && (state_reg != COMMIT);
    assign cfg.cfg_ready = ready;
    assign accept        = cfg.cfg_valid && ready;
    assign word          = cfg.cfg_data;
    assign last          = cfg.cfg_last;
    assign pay_idx       = word[15:8];
    assign pay_func      = word[2:0];

    assign hdr_ok = (word[31:24] == CFG_MAGIC) && (word[23:8] == 16'd0) &&
                    (word[7:0] != 8'd0) && ({1'b0, word[7:0]} <= NUM_PE_W) && !last;
    assign pay_ok = (word[31:16] == 16'd0) && (word[7:3] == 5'd0) &&
                    ({1'b0, pay_idx} < NUM_PE_W) && func_legal(pay_func) && !last;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        csum_next   = csum_reg;
        shadow_next = shadow_reg;
        live_next   = live_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    shadow_next = live_reg;
                    csum_next   = word;
                    cnt_next    = word[7:0];
                    if (hdr_ok) begin
                        state_next = PAYLOAD;
                    end else if (last) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (pay_ok) begin
                        csum_next = csum_reg ^ word;
                        cnt_next  = cnt_reg - 8'd1;
                        // Later writes overwrite earlier ones: duplicates keep the last value
                        for (int i = 0; i < NUM_PE; i++) begin
                            if (pay_idx == 8'(i)) shadow_next[i] = FUNC_W'(pay_func);
                        end
                        if (cnt_reg == 8'd1) state_next = TRAILER;
                    end else if (last) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            TRAILER: begin
                if (accept) begin
                    if (!last) begin
                        state_next = DRAIN;
                    end else if (word == csum_reg) begin
                        state_next = COMMIT;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            COMMIT: begin
                live_next  = shadow_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            DRAIN: begin
                if (accept && last) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            csum_reg  <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
                shadow_reg[i] <= '0;
                live_reg[i]   <= '0;
            end
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            csum_reg   <= csum_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            shadow_reg <= shadow_next;
            live_reg   <= live_next;
        end
    end

    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pack
        assign alu_func_o[gi*FUNC_W +: FUNC_W] = live_reg[gi];
    end

    assign cfg_done = done_reg;
    assign cfg_err  = err_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_pe_func_cfg_loader.sv
// Directed frames into the config loader; a monitor pops expected frame
// outcomes (done/err plus resulting ALU_func vector) on every completion pulse.
module tb_pe_func_cfg_loader;

    localparam int NUM_PE = 4;
    localparam int FUNC_W = 3;
    localparam int AW     = NUM_PE * FUNC_W;

    typedef struct packed {
        logic          is_done;
        logic [AW-1:0] alu;
    } exp_t;

    logic          CLK;
    logic          resetn;
    logic [AW-1:0] alu_func_o;
    logic          cfg_done;
    logic          cfg_err;
    logic          busy;

    pe_func_cfg_loader_if #(.WORD_W(32)) cfg_if ();

    pe_func_cfg_loader #(.NUM_PE(NUM_PE), .FUNC_W(FUNC_W), .WORD_W(32)) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .cfg        (cfg_if),
        .alu_func_o (alu_func_o),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks     = 0;
    int          errors     = 0;
    int          ready_low  = 0;
    int          txn        = 0;
    exp_t        exp_q [$];
    exp_t        e;
    logic [31:0] fr [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts ready-low cycles and checks each completion pulse
    always @(negedge CLK) begin
        if (resetn === 1'b1) begin
            if (cfg_if.cfg_ready !== 1'b1) ready_low++;
            if (cfg_done === 1'b1 || cfg_err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got done=%b err=%b expected no event", cfg_done, cfg_err);
                end else begin
                    e = exp_q.pop_front();
                    txn++;
                    check("event_kind", {30'd0, cfg_done, cfg_err}, e.is_done ? 32'd2 : 32'd1);
                    check("alu_func", {20'd0, alu_func_o}, {20'd0, e.alu});
                    $display("txn %0d: %s alu_func_o=%h (expected %s %h)", txn,
                             cfg_done ? "done" : "err ", alu_func_o,
                             e.is_done ? "done" : "err ", e.alu);
                end
            end
        end
    end

    // Entered and left just after a falling edge
    task automatic send_word(input logic [31:0] d, input logic l, input int gap);
        int t;
        repeat (gap) @(negedge CLK);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = d;
        cfg_if.cfg_last  = l;
        t = 0;
        while (cfg_if.cfg_ready !== 1'b1 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within 50 cycles", cfg_if.cfg_ready);
        end
        @(posedge CLK);
        @(negedge CLK);
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 32'hDEAD_BEEF;
        cfg_if.cfg_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w [$], input int gap_max,
                              input logic is_done, input logic [AW-1:0] alu);
        exp_q.push_back('{is_done: is_done, alu: alu});
        for (int i = 0; i < w.size(); i++) begin
            send_word(w[i], (i == w.size() - 1), (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 32'h0;
        cfg_if.cfg_last  = 1'b0;
        #1;
        check("rst_alu", {20'd0, alu_func_o}, 32'd0);
        check("rst_done", {31'd0, cfg_done}, 32'd0);
        check("rst_err", {31'd0, cfg_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
        repeat (3) @(negedge CLK);
        #2 resetn = 1'b1;
        @(negedge CLK);

        // Good frame: PE0=3, PE2=5
        fr = '{32'hA500_0002, 32'h0000_0003, 32'h0000_0205, 32'hA500_0204};
        send_frame(fr, 0, 1'b1, 12'h143);
        // Same frame with corrupted checksum
        fr = '{32'hA500_0002, 32'h0000_0003, 32'h0000_0205, 32'hA500_0205};
        send_frame(fr, 0, 1'b0, 12'h143);
        // Illegal func code 2, drained to the last word
        fr = '{32'hA500_0003, 32'h0000_0102, 32'h0000_0001, 32'h0000_0000};
        send_frame(fr, 0, 1'b0, 12'h143);
        // PE index out of range
        fr = '{32'hA500_0002, 32'h0000_0401, 32'h0000_0000};
        send_frame(fr, 0, 1'b0, 12'h143);
        // N=0 header
        fr = '{32'hA500_0000, 32'h0000_0000};
        send_frame(fr, 0, 1'b0, 12'h143);
        // N=5 > NUM_PE
        fr = '{32'hA500_0005, 32'h0000_0001, 32'h0000_0002};
        send_frame(fr, 0, 1'b0, 12'h143);
        // cfg_last on the header itself
        fr = '{32'hA500_0001};
        send_frame(fr, 0, 1'b0, 12'h143);
        // Bad magic
        fr = '{32'hB500_0001, 32'h0000_0001, 32'h0000_0000};
        send_frame(fr, 0, 1'b0, 12'h143);
        // cfg_last on a payload word
        fr = '{32'hA500_0002, 32'h0000_0001};
        send_frame(fr, 0, 1'b0, 12'h143);
        // Correct checksum but trailer lacks cfg_last -> drained
        fr = '{32'hA500_0001, 32'h0000_0104, 32'hA500_0105, 32'h0000_0000};
        send_frame(fr, 0, 1'b0, 12'h143);

        // Stalled frame with duplicate PE3 index, then a back-to-back frame
        fr = '{32'hA500_0003, 32'h0000_0301, 32'h0000_0106, 32'h0000_0304, 32'hA500_0100};
        send_frame(fr, 3, 1'b1, 12'h973);
        fr = '{32'hA500_0001, 32'h0000_0000, 32'hA500_0001};
        send_frame(fr, 0, 1'b1, 12'h970);

        // Reset while in PAYLOAD
        repeat (2) @(negedge CLK);
        check("alu_before_reset", {20'd0, alu_func_o}, 32'h970);
        send_word(32'hA500_0002, 1'b0, 0);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        send_word(32'h0000_0205, 1'b0, 0);
        #2 resetn = 1'b0;
        #1;
        check("midrst_alu", {20'd0, alu_func_o}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
        repeat (2) @(negedge CLK);
        #2 resetn = 1'b1;
        @(negedge CLK);
        fr = '{32'hA500_0001, 32'h0000_0105, 32'hA500_0104};
        send_frame(fr, 0, 1'b1, 12'h028);

        repeat (5) @(negedge CLK);
        check("queue_empty", exp_q.size(), 32'd0);
        check("ready_low_cycles", ready_low, 32'd4);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_func_cfg_loader.md
Name: pe_func_cfg_loader

Overview:
- Runtime configuration loader that receives framed config words over a valid/ready stream and decodes them into per-PE ALU_func select fields.
- Drives the ALU_func config inputs of NUM_PE PE tiles.
- Frames are checked (magic, count, index, legal func code, XOR checksum) in a shadow register. Only a fully valid frame is committed atomically to the live outputs.

Parameters:
- NUM_PE, 4, number of PE ALU_func fields driven (1..255)
- FUNC_W, 3, width of one ALU_func field
- WORD_W, 32, config stream word width (fixed 32; other values unsupported)

Ports:
- CLK  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  loader accepts word when cfg_valid & cfg_ready
- cfg_data  in  WORD_W  config word
- cfg_last  in  1  marks final word of frame
- alu_func_o  out  NUM_PE*FUNC_W  live ALU_func per PE; PE i at bits [i*FUNC_W +: FUNC_W]
- cfg_done  out  1  one-cycle pulse on successful commit
- cfg_err  out  1  one-cycle pulse when an errored frame finishes (cfg_last accepted)
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, resetn=0):
  - alu_func_o=0 (all PEs func 0).
  - cfg_done=0, cfg_err=0, busy=0.
  - State IDLE; shadow and checksum cleared.
  - cfg_ready=0 while in reset.
- Frame format:
  - Header: [31:24]=8'hA5, [23:8]=0, [7:0]=N.
  - N payload words: [31:16]=0, [15:8]=PE index, [7:3]=0, [2:0]=func.
  - Trailer: XOR of header and all payload words.
  - cfg_last must be set on the trailer only.
- Legal func codes: 0,1,3,4,5,6. Codes 2 and 7 are errors.
- States:
  - IDLE: cfg_ready=1. On accept, check header; shadow<=alu_func_o, csum<=word.
    - Bad magic, nonzero reserved bits, N=0, N>NUM_PE, or cfg_last=1: go to DRAIN, or straight back to IDLE with cfg_err pulse if cfg_last=1.
    - Otherwise go to PAYLOAD with cnt=N.
  - PAYLOAD: cfg_ready=1. Per accepted word: csum^=word, shadow[index]<=func, cnt--.
    - Index>=NUM_PE, illegal func, nonzero reserved bits, or cfg_last=1 is an error: go to DRAIN, or IDLE with cfg_err if cfg_last.
    - When cnt reaches 0, go to TRAILER.
  - TRAILER: cfg_ready=1. Accepted word must equal csum and have cfg_last=1.
    - Match: go to COMMIT.
    - Mismatch with cfg_last=1: go to IDLE, cfg_err pulse.
    - cfg_last=0: go to DRAIN.
  - COMMIT: cfg_ready=0 for exactly one cycle. At that edge alu_func_o<=shadow and cfg_done<=1 (one cycle); then IDLE.
  - DRAIN: cfg_ready=1. Discard words until one with cfg_last=1 is accepted, then IDLE with cfg_err pulse at that edge.
- Latency: trailer accepted at edge k; alu_func_o and cfg_done change at edge k+1; next header can be accepted at edge k+2.
- Duplicate PE index within one frame: last write wins.
- PEs not listed in a frame keep their current value.
- Errored frames never modify alu_func_o.
- cfg_valid=0 stalls all states except COMMIT; no timeout.
- Reset mid-frame: shadow discarded, alu_func_o returns to 0 immediately.
- cfg_data is ignored when cfg_valid=0.

Decomposition:
- Shared package pe_cfg_pkg holds:
  - CFG_MAGIC=8'hA5
  - the state enum {IDLE,PAYLOAD,TRAILER,COMMIT,DRAIN}
  - the ALU_func code constants (ADD..=0,1,3,4,5,6 as named localparams)
  - function func_legal(code)
- No sub-module; a single FSM plus shadow/checksum registers.

Test Plan:
- Valid frame: hdr A5000002, words 00000003 (PE0=3), 00000205 (PE2=5), trailer = XOR of all three → cfg_done pulses 1 cycle after the trailer; alu_func_o: PE0=3, PE2=5, PE1=PE3=0; cfg_err=0.
- Bad checksum: same frame with trailer ^1 → cfg_err pulse, alu_func_o unchanged, cfg_done=0.
- Illegal func: payload func=2 (or index 4 with NUM_PE=4), then 2 more words, last on the final word → ready stays 1 through DRAIN, cfg_err pulses on the last word only, outputs unchanged.
- Header N=0 and N=5 → error path; cfg_last on the header → immediate cfg_err pulse, back to IDLE.
- Backpressure/stall: random cfg_valid gaps, back-to-back frames → cfg_ready=0 only in the COMMIT cycle, second frame commits correctly, duplicate index resolves to the last value.
- Reset: assert resetn=0 mid-PAYLOAD after a prior commit → alu_func_o=0 asynchronously, busy=0; a new valid frame after release commits normally.
